// File: rtl/mix_layer_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mix_layer_sched_pkg
// Purpose : Shared constants for the mix_layer training-step sequencer:
//           layer state-select width and codes, default batch size and the
//           4-bit sequencer state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package mix_layer_sched_pkg;

   localparam int STATE_LEN  = 4;
   localparam logic [STATE_LEN-1:0] F_MIX2 = 4'd5;
   localparam logic [STATE_LEN-1:0] B_MIX2 = 4'd10;
   localparam int BATCH_SIZE = 4;

   typedef enum logic [3:0] {
      SCH_IDLE = 4'd0,
      SCH_S1   = 4'd1,
      SCH_GAP  = 4'd2,
      SCH_LD   = 4'd3,
      SCH_S2   = 4'd4,
      SCH_LDL  = 4'd5,
      SCH_S3   = 4'd6,
      SCH_UPD  = 4'd7,
      SCH_DONE = 4'd8
   } sch_state_t;

endpackage
`default_nettype wire

// File: rtl/mix_layer_sched_run_handshake.sv
`default_nettype none
// ============================================================================
// Module  : run_handshake
// Purpose : One run/valid pair with a sticky completion flag.
//           arm   : raise run and clear the completion flag
//           valid : completion flag from the layer, honoured only while run
//           run   : registered run request to the layer
//           fin   : completion seen (sticky flag, or valid sampled this cycle)
// Revision: 1.0 - initial release
// ============================================================================
module run_handshake (
   input  logic clk,
   input  logic rst,
   input  logic arm,
   input  logic valid,
   output logic run,
   output logic fin
);

   logic r_run;
   logic r_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_run  <= 1'b0;
         r_done <= 1'b0;
      end else if (arm) begin
         r_run  <= 1'b1;
         r_done <= 1'b0;
      end else if (r_run && valid) begin
         r_run  <= 1'b0;
         r_done <= 1'b1;
      end
   end

   assign run = r_run;
   // Includes the current-cycle completion so the sequencer can leave its
   // phase on the same edge that drops run.
   assign fin = r_done | (r_run & valid);

endmodule
`default_nettype wire

// File: rtl/mix_layer_sched.sv
`default_nettype none
// ============================================================================
// Module  : mix_layer_sched
// Purpose : Training-step sequencer for one mix_layer. Runs one mini-batch
//           through S1 -> S2 x (BATCH_SIZE-1) -> S3 -> UPDATE.
// Ports   : clk, rst (sync, active-high), start
//           busy, done                         - status
//           zero_grad, run_forward, run_backward,
//           load_backward, update              - layer controls
//           state_forward, state_backward      - layer state selects
//           valid_zero_grad/forward/backward/update - layer completion levels
//           fwd_idx, bwd_idx                   - sample indices
// Revision: 1.0 - initial release
// ============================================================================
module mix_layer_sched
   import mix_layer_sched_pkg::*;
#(
   parameter int BATCH_SIZE = mix_layer_sched_pkg::BATCH_SIZE,
   parameter logic [STATE_LEN-1:0] F_STATE = F_MIX2,
   parameter logic [STATE_LEN-1:0] B_STATE = B_MIX2,
   localparam int IDX_W = $clog2(BATCH_SIZE + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 zero_grad,
   output logic                 run_forward,
   output logic                 run_backward,
   output logic                 load_backward,
   output logic                 update,
   output logic [STATE_LEN-1:0] state_forward,
   output logic [STATE_LEN-1:0] state_backward,
   input  logic                 valid_zero_grad,
   input  logic                 valid_forward,
   input  logic                 valid_backward,
   input  logic                 valid_update,
   output logic [IDX_W-1:0]     fwd_idx,
   output logic [IDX_W-1:0]     bwd_idx
);

   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(BATCH_SIZE - 1);

   sch_state_t r_state;
   sch_state_t r_target;
   sch_state_t w_state_nxt;

   logic w_fwd_arm, w_bwd_arm;
   logic w_fwd_valid;
   logic w_fwd_fin, w_bwd_fin;
   logic w_all_low;

   // The forward pair also serves S1, where completion needs zero_grad too.
   assign w_fwd_valid = (r_state == SCH_S1) ? (valid_forward & valid_zero_grad)
                                            : valid_forward;
   assign w_fwd_arm   = ((r_state == SCH_IDLE) && start) || (r_state == SCH_LD);
   assign w_bwd_arm   = (r_state == SCH_LD) || (r_state == SCH_LDL);
   assign w_all_low   = ~(valid_zero_grad | valid_forward | valid_backward | valid_update);

   run_handshake u_fwd_hs (
      .clk   (clk),
      .rst   (rst),
      .arm   (w_fwd_arm),
      .valid (w_fwd_valid),
      .run   (run_forward),
      .fin   (w_fwd_fin)
   );

   run_handshake u_bwd_hs (
      .clk   (clk),
      .rst   (rst),
      .arm   (w_bwd_arm),
      .valid (valid_backward),
      .run   (run_backward),
      .fin   (w_bwd_fin)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SCH_IDLE: if (start)                   w_state_nxt = SCH_S1;
         SCH_S1:   if (w_fwd_fin)               w_state_nxt = SCH_GAP;
         // GAP only releases once every level is low, so the next run can
         // only complete on a fresh valid.
         SCH_GAP:  if (w_all_low)               w_state_nxt = r_target;
         SCH_LD:                                w_state_nxt = SCH_S2;
         SCH_S2:   if (w_fwd_fin && w_bwd_fin)  w_state_nxt = SCH_GAP;
         SCH_LDL:                               w_state_nxt = SCH_S3;
         SCH_S3:   if (w_bwd_fin)               w_state_nxt = SCH_GAP;
         SCH_UPD:  if (valid_update)            w_state_nxt = SCH_DONE;
         SCH_DONE:                              w_state_nxt = SCH_IDLE;
         default:                               w_state_nxt = SCH_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so each is registered and lines
   // up with the state it belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= SCH_IDLE;
         r_target       <= SCH_IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         zero_grad      <= 1'b0;
         load_backward  <= 1'b0;
         update         <= 1'b0;
         state_forward  <= '0;
         state_backward <= '0;
         fwd_idx        <= '0;
         bwd_idx        <= '0;
      end else begin
         r_state        <= w_state_nxt;
         busy           <= (w_state_nxt != SCH_IDLE);
         done           <= (w_state_nxt == SCH_DONE);
         zero_grad      <= (w_state_nxt == SCH_S1);
         load_backward  <= (w_state_nxt == SCH_LD) || (w_state_nxt == SCH_LDL);
         update         <= (w_state_nxt == SCH_UPD);
         state_forward  <= (w_state_nxt != SCH_IDLE) ? F_STATE : '0;
         state_backward <= (w_state_nxt != SCH_IDLE) ? B_STATE : '0;

         if (w_state_nxt == SCH_GAP) begin
            case (r_state)
               SCH_S1:  r_target <= (BATCH_SIZE == 1) ? SCH_LDL : SCH_LD;
               SCH_S2:  r_target <= (fwd_idx == c_last_idx) ? SCH_LDL : SCH_LD;
               SCH_S3:  r_target <= SCH_UPD;
               default: r_target <= r_target;
            endcase
         end

         if ((r_state == SCH_IDLE) && start) begin
            fwd_idx <= '0;
            bwd_idx <= '0;
         end else if (w_state_nxt == SCH_LD) begin
            // The sample just forwarded becomes the backward sample.
            fwd_idx <= fwd_idx + IDX_W'(1);
            bwd_idx <= fwd_idx;
         end else if (w_state_nxt == SCH_LDL) begin
            bwd_idx <= c_last_idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mix_layer_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_mix_layer_sched
// Purpose : Self-checking bench for mix_layer_sched (BATCH_SIZE 2 and 1
//           builds) with a delay-programmable layer model and an event
//           scoreboard keyed on rising control outputs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mix_layer_sched;
   import mix_layer_sched_pkg::*;

   typedef logic [9:0] ev_t;   // {rise mask[5:0], fwd_idx[1:0], bwd_idx[1:0]}

   localparam logic [5:0] M_ZG = 6'b100000;
   localparam logic [5:0] M_RF = 6'b010000;
   localparam logic [5:0] M_RB = 6'b001000;
   localparam logic [5:0] M_LD = 6'b000100;
   localparam logic [5:0] M_UP = 6'b000010;
   localparam logic [5:0] M_DN = 6'b000001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start2 = 1'b0;
   logic start1 = 1'b0;

   logic d2_busy, d2_done, d2_zg, d2_rf, d2_rb, d2_ld, d2_upd;
   logic [STATE_LEN-1:0] d2_sf, d2_sb;
   logic [1:0] d2_fidx, d2_bidx;
   logic d1_busy, d1_done, d1_zg, d1_rf, d1_rb, d1_ld, d1_upd;
   logic [STATE_LEN-1:0] d1_sf, d1_sb;
   logic [0:0] d1_fidx, d1_bidx;

   logic [7:0] vals;
   logic [7:0] runs;
   int dly[8];
   int hold[8];
   int cnt[8];
   int hcnt[8];

   int checks = 0;
   int errors = 0;
   ev_t q2[$];
   ev_t q1[$];

   always #5 clk = ~clk;

   mix_layer_sched #(.BATCH_SIZE(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .busy(d2_busy), .done(d2_done),
      .zero_grad(d2_zg), .run_forward(d2_rf), .run_backward(d2_rb),
      .load_backward(d2_ld), .update(d2_upd),
      .state_forward(d2_sf), .state_backward(d2_sb),
      .valid_zero_grad(vals[0]), .valid_forward(vals[1]),
      .valid_backward(vals[2]), .valid_update(vals[3]),
      .fwd_idx(d2_fidx), .bwd_idx(d2_bidx)
   );

   mix_layer_sched #(.BATCH_SIZE(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .busy(d1_busy), .done(d1_done),
      .zero_grad(d1_zg), .run_forward(d1_rf), .run_backward(d1_rb),
      .load_backward(d1_ld), .update(d1_upd),
      .state_forward(d1_sf), .state_backward(d1_sb),
      .valid_zero_grad(vals[4]), .valid_forward(vals[5]),
      .valid_backward(vals[6]), .valid_update(vals[7]),
      .fwd_idx(d1_fidx), .bwd_idx(d1_bidx)
   );

   assign runs = {d1_upd, d1_rb, d1_rf, d1_zg, d2_upd, d2_rb, d2_rf, d2_zg};

   // Layer model: each valid rises dly cycles after its run request is seen,
   // stays up while the request is up, then lingers hold cycles after it drops.
   initial begin
      vals = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 8; i++) begin
            if (rst) begin
               vals[i] = 1'b0; cnt[i] = 0; hcnt[i] = 0;
            end else if (runs[i]) begin
               hcnt[i] = 0;
               if (!vals[i]) begin
                  cnt[i]++;
                  if (cnt[i] >= dly[i]) vals[i] = 1'b1;
               end
            end else begin
               cnt[i] = 0;
               if (vals[i]) begin
                  if (hcnt[i] >= hold[i]) begin
                     vals[i] = 1'b0; hcnt[i] = 0;
                  end else begin
                     hcnt[i]++;
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic ev_t ev(input logic [5:0] m, input int f, input int b);
      return {m, 2'(f), 2'(b)};
   endfunction

   task automatic push_batch2();
      q2.push_back(ev(M_ZG | M_RF, 0, 0));
      q2.push_back(ev(M_LD,        1, 0));
      q2.push_back(ev(M_RF | M_RB, 1, 0));
      q2.push_back(ev(M_LD,        1, 1));
      q2.push_back(ev(M_RB,        1, 1));
      q2.push_back(ev(M_UP,        1, 1));
      q2.push_back(ev(M_DN,        1, 1));
   endtask

   task automatic push_batch1();
      q1.push_back(ev(M_ZG | M_RF, 0, 0));
      q1.push_back(ev(M_LD,        0, 0));
      q1.push_back(ev(M_RB,        0, 0));
      q1.push_back(ev(M_UP,        0, 0));
      q1.push_back(ev(M_DN,        0, 0));
   endtask

   task automatic set_dly(input int d);
      for (int i = 0; i < 8; i++) begin
         dly[i] = d; hold[i] = 0;
      end
   endtask

   task automatic pulse_start2();
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
   endtask

   task automatic wait_idle2(input string name);
      int n = 0;
      do begin
         @(negedge clk); n++;
      end while (d2_busy && n < 2000);
      chk(name, d2_busy, 1'b0);
   endtask

   task automatic wait_s2(input string name);
      int n = 0;
      while (!(d2_rf && d2_rb) && n < 500) begin
         @(negedge clk); n++;
      end
      chk(name, d2_rf && d2_rb, 1'b1);
   endtask

   // Scoreboard monitors: any cycle with a rising control output is an event.
   initial begin
      logic [5:0] prev, cur, rise;
      prev = '0;
      forever begin
         @(negedge clk);
         cur  = {d2_zg, d2_rf, d2_rb, d2_ld, d2_upd, d2_done};
         rise = cur & ~prev;
         prev = cur;
         if (rise != 0) begin
            if (q2.size() == 0) begin
               checks++; errors++;
               $display("FAIL mon2_event: got %h expected none", {rise, d2_fidx, d2_bidx});
            end else begin
               chk("mon2_event", {rise, d2_fidx, d2_bidx}, q2.pop_front());
            end
         end
      end
   end

   initial begin
      logic [5:0] prev, cur, rise;
      prev = '0;
      forever begin
         @(negedge clk);
         cur  = {d1_zg, d1_rf, d1_rb, d1_ld, d1_upd, d1_done};
         rise = cur & ~prev;
         prev = cur;
         if (rise != 0) begin
            if (q1.size() == 0) begin
               checks++; errors++;
               $display("FAIL mon1_event: got %h expected none", {rise, 1'b0, d1_fidx, 1'b0, d1_bidx});
            end else begin
               chk("mon1_event", {rise, 1'b0, d1_fidx, 1'b0, d1_bidx}, q1.pop_front());
            end
         end
      end
   end

   initial begin
      int k, kf, kb, kl, n;
      logic reasserted;
      set_dly(10);

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ctrl2", {d2_busy, d2_done, d2_zg, d2_rf, d2_rb, d2_ld, d2_upd}, 7'd0);
      chk("rst_sel2", {d2_sf, d2_sb}, '0);
      chk("rst_idx2", {d2_fidx, d2_bidx}, 4'd0);
      chk("rst_ctrl1", {d1_busy, d1_done, d1_zg, d1_rf, d1_rb, d1_ld, d1_upd}, 7'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single batch, all valids 10 cycles after the request
      push_batch2();
      pulse_start2();
      chk("t1_busy", d2_busy, 1'b1);
      chk("t1_zg_rf", {d2_zg, d2_rf}, 2'b11);
      chk("t1_state_fwd", d2_sf, F_MIX2);
      chk("t1_state_bwd", d2_sb, B_MIX2);
      n = 0;
      while (!d2_upd && n < 500) begin @(negedge clk); n++; end
      chk("t1_update_seen", d2_upd, 1'b1);
      k = 0;
      while (d2_upd && k < 100) begin @(negedge clk); k++; end
      chk("t1_update_len", k, 10);
      chk("t1_done", d2_done, 1'b1);
      @(negedge clk);
      chk("t1_done_pulse", d2_done, 1'b0);
      chk("t1_busy_low", d2_busy, 1'b0);
      chk("t1_sel_idle", d2_sf, '0);

      // Skewed completion in S2
      dly[1] = 3; dly[2] = 40;
      push_batch2();
      pulse_start2();
      wait_s2("t2_s2_seen");
      k = 0; kf = -1; kb = -1; kl = -1;
      while (kl < 0 && k < 200) begin
         @(negedge clk); k++;
         if (!d2_rf && kf < 0) kf = k;
         if (!d2_rb && kb < 0) kb = k;
         if (d2_ld && kl < 0) kl = k;
      end
      chk("t2_fwd_drop", kf, 3);
      chk("t2_bwd_drop", kb, 40);
      chk("t2_ldl_after", kl, 41);
      wait_idle2("t2_idle");

      // Stale forward valid lingering through GAP
      set_dly(5);
      hold[1] = 5;
      push_batch2();
      pulse_start2();
      n = 0;
      while (d2_rf && n < 200) begin @(negedge clk); n++; end
      k = 0; reasserted = 1'b0;
      while (!d2_ld && k < 100) begin
         @(negedge clk); k++;
         if (d2_rf) reasserted = 1'b1;
      end
      chk("t3_gap_len", k, 6);
      chk("t3_no_rerun", reasserted, 1'b0);
      wait_idle2("t3_idle");
      set_dly(40);

      // Reset during S2, then a clean batch
      q2.push_back(ev(M_ZG | M_RF, 0, 0));
      q2.push_back(ev(M_LD,        1, 0));
      q2.push_back(ev(M_RF | M_RB, 1, 0));
      pulse_start2();
      wait_s2("t4_s2_seen");
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t4_abort_outs", {d2_busy, d2_done, d2_zg, d2_rf, d2_rb, d2_ld, d2_upd,
                            d2_sf, d2_sb, d2_fidx, d2_bidx}, '0);
      chk("t4_queue_empty", q2.size(), 0);
      rst = 1'b0;
      set_dly(10);
      @(negedge clk);
      push_batch2();
      pulse_start2();
      wait_idle2("t4_clean_idle");

      // start during busy and during done is ignored; the cycle after done starts
      push_batch2();
      pulse_start2();
      repeat (4) @(negedge clk);
      pulse_start2();
      n = 0;
      while (!d2_done && n < 500) begin @(negedge clk); n++; end
      chk("t5_done_seen", d2_done, 1'b1);
      start2 = 1'b1;
      @(negedge clk);
      chk("t5_done_start_ignored", d2_busy, 1'b0);
      push_batch2();
      @(negedge clk);
      start2 = 1'b0;
      chk("t5_restart", d2_busy, 1'b1);
      wait_idle2("t5_idle");

      // BATCH_SIZE = 1 build
      push_batch1();
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (d1_busy && n < 2000);
      chk("t6_idle", d1_busy, 1'b0);
      chk("t6_bwd_idx", d1_bidx, 1'b0);

      repeat (3) @(negedge clk);
      chk("final_q2_empty", q2.size(), 0);
      chk("final_q1_empty", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
